// File: rtl/add16_pkg.sv
// Shared types and the round-robin search used by the Add16 arbiter.
package add16_pkg;

    localparam int WORD_W  = 16;
    localparam int MAX_REQ = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [2:0] id;
        word_t      s;
        logic       c;
    } add_rsp_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit at or above ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 nreq);
        rr_pick_t r;
        int       j;
        r.found = 1'b0;
        r.idx   = 3'd0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= nreq) begin
                j = j - nreq;
            end else begin
                j = j;
            end
            if ((k < nreq) && !r.found && valid[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/add16.sv
// Plain 16-bit adder with carry-out; the shared datapath behind the arbiter.
module add16
    import add16_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    output logic [WORD_W-1:0] S,
    output logic              C
);

    assign {C, S} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/add16_arbiter.sv
// Round-robin arbiter sharing one add16 among NREQ requesters, with a single
// registered response slot that supports one result per cycle.
module add16_arbiter
    import add16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NREQ-1:0]        REQ_VALID,
    output logic [NREQ-1:0]        REQ_READY,
    input  logic [WORD_W*NREQ-1:0] REQ_A,
    input  logic [WORD_W*NREQ-1:0] REQ_B,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [IDW-1:0]         RSP_ID,
    output logic [WORD_W-1:0]      RSP_S,
    output logic                   RSP_C
);

    word_t          opa_q, opa_d, opb_q, opb_d;
    logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d;
    logic           valid_q, valid_d;
    logic           acc_s, grant_s;
    logic [2:0]     nxt_s;
    rr_pick_t       pick_s;
    add_rsp_t       rsp_s;
    word_t          sum_s;
    logic           carry_s;

    // Grant selection and next-state; a grant while the slot drains refills it.
    always_comb begin
        acc_s     = !valid_q || RSP_READY;
        pick_s    = rr_pick(MAX_REQ'(REQ_VALID), 3'(ptr_q), NREQ);
        grant_s   = RST_N && acc_s && pick_s.found;
        nxt_s     = (int'(pick_s.idx) == NREQ - 1) ? 3'd0 : pick_s.idx + 3'd1;
        REQ_READY = '0;
        opa_d     = opa_q;
        opb_d     = opb_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q && !RSP_READY;
        if (grant_s) begin
            REQ_READY = {{(NREQ-1){1'b0}}, 1'b1} << pick_s.idx;
            opa_d     = REQ_A[int'(pick_s.idx)*WORD_W +: WORD_W];
            opb_d     = REQ_B[int'(pick_s.idx)*WORD_W +: WORD_W];
            id_d      = IDW'(pick_s.idx);
            ptr_d     = IDW'(nxt_s);
            valid_d   = 1'b1;
        end else begin
            REQ_READY = '0;
        end
    end

    // Operand, owner, pointer and valid registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            opa_q   <= '0;
            opb_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    add16 u_add16 (
        .A (opa_q),
        .B (opb_q),
        .S (sum_s),
        .C (carry_s)
    );

    assign rsp_s     = '{id: 3'(id_q), s: sum_s, c: carry_s};
    assign RSP_VALID = valid_q;
    assign RSP_ID    = IDW'(rsp_s.id);
    assign RSP_S     = rsp_s.s;
    assign RSP_C     = rsp_s.c;

endmodule

// File: tb/tb_add16_arbiter.sv
// Self-checking bench: a reference model with a response scoreboard plus a
// table of adder vectors and hand-written backpressure/reset sequences.
module tb_add16_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [NREQ-1:0]   REQ_VALID;
    logic [NREQ-1:0]   REQ_READY;
    logic [16*NREQ-1:0] REQ_A, REQ_B;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [IDW-1:0]    RSP_ID;
    logic [15:0]       RSP_S;
    logic              RSP_C;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] s;
        logic        c;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        c;
    } vec_t;

    exp_t        sb[$];
    int unsigned ptr_m;
    int          errors = 0;
    int          checks = 0;

    add16_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_ID(RSP_ID), .RSP_S(RSP_S), .RSP_C(RSP_C)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model grant from the model pointer and current inputs.
    function automatic int model_grant();
        bit acc;
        acc = (sb.size() == 0) || RSP_READY;
        if (!RST_N || !acc) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr_m + k) % NREQ;
            if (REQ_VALID[j]) return j;
        end
        return -1;
    endfunction

    // One clock: check outputs against model, then advance model at the edge.
    task automatic cycle();
        int   g;
        exp_t e;
        logic [16:0] sum;
        #1;
        g = model_grant();
        chk("req_ready", 32'(REQ_READY), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("rsp_valid", 32'(RSP_VALID), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("sb_id", 32'(RSP_ID), 32'(sb[0].id));
            chk("sb_s",  32'(RSP_S),  32'(sb[0].s));
            chk("sb_c",  32'(RSP_C),  32'(sb[0].c));
        end
        @(posedge CLK);
        if (!RST_N) begin
            sb.delete();
            ptr_m = 0;
        end else begin
            if (sb.size() != 0 && RSP_READY) void'(sb.pop_front());
            if (g >= 0) begin
                sum  = {1'b0, REQ_A[16*g +: 16]} + {1'b0, REQ_B[16*g +: 16]};
                e.id = 2'(g);
                e.s  = sum[15:0];
                e.c  = sum[16];
                sb.push_back(e);
                ptr_m = (g + 1) % NREQ;
            end
        end
        @(negedge CLK);
    endtask

    task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b);
        REQ_A[16*i +: 16] = a;
        REQ_B[16*i +: 16] = b;
    endtask

    vec_t vecs[5];
    int   rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        vecs[0] = '{a: 16'hFFFF, b: 16'hFFFF, s: 16'hFFFE, c: 1'b1};
        vecs[1] = '{a: 16'h8000, b: 16'h8000, s: 16'h0000, c: 1'b1};
        vecs[2] = '{a: 16'h0000, b: 16'h0000, s: 16'h0000, c: 1'b0};
        vecs[3] = '{a: 16'hFFFF, b: 16'h0001, s: 16'h0000, c: 1'b1};
        vecs[4] = '{a: 16'h7FFF, b: 16'h0001, s: 16'h8000, c: 1'b0};

        ptr_m     = 0;
        RST_N     = 1'b0;
        REQ_VALID = '1;
        RSP_READY = 1'b1;
        for (int i = 0; i < NREQ; i++) set_lane(i, 16'(i * 16'h0101), 16'(16'h1000 + i));
        @(posedge CLK);
        @(negedge CLK);

        // Reset held for three cycles with every requester pending.
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_s",  32'(RSP_S),  32'd0);
            chk("rst_c",  32'(RSP_C),  32'd0);
            chk("rst_id", 32'(RSP_ID), 32'd0);
            cycle();
        end

        // Release: round robin 0,1,2,3,0 with results one per cycle.
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_grant", 32'(REQ_READY), 32'd1 << rr_exp[i]);
            cycle();
        end
        REQ_VALID = '0;
        cycle();
        cycle();

        // Single request from requester 1.
        set_lane(1, 16'h1234, 16'h0F0F);
        REQ_VALID = 4'b0010;
        cycle();
        REQ_VALID = '0;
        #1;
        chk("single_v", 32'(RSP_VALID), 32'd1);
        chk("single_id", 32'(RSP_ID), 32'd1);
        chk("single_s", 32'(RSP_S), 32'h2143);
        chk("single_c", 32'(RSP_C), 32'd0);
        cycle();
        #1;
        chk("single_drain", 32'(RSP_VALID), 32'd0);

        // Adder vectors through rotating lanes.
        for (int i = 0; i < 5; i++) begin
            set_lane(i % NREQ, vecs[i].a, vecs[i].b);
            REQ_VALID = 4'(1 << (i % NREQ));
            cycle();
            REQ_VALID = '0;
            #1;
            chk("vec_s", 32'(RSP_S), 32'(vecs[i].s));
            chk("vec_c", 32'(RSP_C), 32'(vecs[i].c));
            cycle();
        end

        // Backpressure: requester 2 result held while requester 3 waits.
        set_lane(2, 16'hFFFF, 16'h0001);
        set_lane(3, 16'h0003, 16'h0004);
        REQ_VALID = 4'b0100;
        cycle();
        REQ_VALID = 4'b1000;
        RSP_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_ready", 32'(REQ_READY), 32'd0);
            chk("bp_id", 32'(RSP_ID), 32'd2);
            chk("bp_s", 32'(RSP_S), 32'h0000);
            chk("bp_c", 32'(RSP_C), 32'd1);
            cycle();
        end
        RSP_READY = 1'b1;
        #1;
        chk("bp_release", 32'(REQ_READY), 32'b1000);
        cycle();
        REQ_VALID = '0;
        #1;
        chk("bp_next_id", 32'(RSP_ID), 32'd3);
        chk("bp_next_s", 32'(RSP_S), 32'h0007);
        cycle();

        // Reset while a result is held and unaccepted.
        set_lane(1, 16'h0101, 16'h0202);
        REQ_VALID = 4'b0010;
        cycle();
        REQ_VALID = '0;
        RSP_READY = 1'b0;
        cycle();
        RST_N = 1'b0;
        cycle();
        #1;
        chk("mid_rst_v", 32'(RSP_VALID), 32'd0);
        RST_N     = 1'b1;
        RSP_READY = 1'b1;
        REQ_VALID = '1;
        #1;
        chk("mid_rst_ptr", 32'(REQ_READY), 32'b0001);
        cycle();
        REQ_VALID = '0;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
